// File: rtl/press_pkg.sv
// press_pkg: shared state encoding and default constants for the press decoder
package press_pkg;
    localparam int CNT_W        = 10;
    localparam int LONG_CYC_DEF = 16;
    localparam int DBL_GAP_DEF  = 8;
    localparam logic [2:0] ARM    = 3'd0;
    localparam logic [2:0] IDLE   = 3'd1;
    localparam logic [2:0] PRESS1 = 3'd2;
    localparam logic [2:0] WAIT2  = 3'd3;
    localparam logic [2:0] HELD   = 3'd4;
endpackage

// File: rtl/press_timer.sv
// press_timer: gesture cycle counter with clear-to-1, increment and terminal compare
//   clk, rst     : clock, synchronous active-high reset (count returns to 0)
//   clr_i        : load count with 1 (first sample of a new phase)
//   inc_i        : advance count by one
//   term_i       : terminal value compared against the current count
//   tc_o         : high while count equals term_i
module press_timer
    import press_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             tc_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr_i ? CNT_W'(1) : inc_i ? cnt_q + CNT_W'(1) : cnt_q;
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
    assign tc_o = cnt_q == term_i;
endmodule

// File: rtl/press_decoder.sv
// press_decoder: classifies button activity into short, long and double press pulses
//   clk, rst  : clock, synchronous active-high reset
//   btn       : debounced clk-synchronous button level, 1 = pressed
//   short_p   : one-cycle pulse for a single short press
//   long_p    : one-cycle pulse for a long press
//   double_p  : one-cycle pulse for a double press
//   busy      : high while a gesture is being classified or held
module press_decoder
    import press_pkg::*;
#(
    parameter int LONG_CYC = LONG_CYC_DEF,
    parameter int DBL_GAP  = DBL_GAP_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic short_p,
    output logic long_p,
    output logic double_p,
    output logic busy
);
    localparam logic [CNT_W-1:0] LONG_T = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DBL_T  = CNT_W'(DBL_GAP - 1);
    logic [2:0] state_q, state_d;
    logic       short_q, short_d, long_q, long_d, dbl_q, dbl_d;
    logic       clr, inc, tc;
    logic [CNT_W-1:0] term;
    assign term = state_q == PRESS1 ? LONG_T : DBL_T;
    press_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr),
        .inc_i  (inc),
        .term_i (term),
        .tc_o   (tc)
    );
    // Release beats the long threshold and a new press beats the gap timeout,
    // so the btn test comes before the terminal-count test in both phases.
    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        inc     = 1'b0;
        short_d = 1'b0;
        long_d  = 1'b0;
        dbl_d   = 1'b0;
        case (state_q)
            ARM:  state_d = btn ? ARM : IDLE;
            IDLE: begin
                state_d = btn ? PRESS1 : IDLE;
                clr     = btn;
            end
            PRESS1: begin
                state_d = !btn ? WAIT2 : tc ? HELD : PRESS1;
                clr     = !btn;
                long_d  = btn && tc;
                inc     = btn && !tc;
            end
            WAIT2: begin
                state_d = btn ? HELD : tc ? IDLE : WAIT2;
                dbl_d   = btn;
                short_d = !btn && tc;
                inc     = !btn && !tc;
            end
            HELD:    state_d = btn ? HELD : IDLE;
            default: state_d = ARM;
        endcase
    end
    always_ff @(posedge clk) begin
        state_q <= rst ? ARM  : state_d;
        short_q <= rst ? 1'b0 : short_d;
        long_q  <= rst ? 1'b0 : long_d;
        dbl_q   <= rst ? 1'b0 : dbl_d;
    end
    assign short_p  = short_q;
    assign long_p   = long_q;
    assign double_p = dbl_q;
    assign busy     = state_q == PRESS1 || state_q == WAIT2 || state_q == HELD;
endmodule
